// File: rtl/freqdiv_pkg.sv
// Shared types and constants for the programmable frequency-divider controller.
package freqdiv_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Smallest divisor that still yields a distinct low and high half.
  localparam int unsigned MIN_DIV             = 2;
  localparam int unsigned FREQDIV_DEFAULT_DIV = 100;

endpackage

// File: rtl/freqdiv_core.sv
// Period counter: wraps at div-1 and derives the divided level from the count.
module freqdiv_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             clk_out
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_high_from;

  assign w_last      = div - WIDTH'(1);
  // Low half gets the extra cycle for odd divisors (5 -> 3 low, 2 high).
  assign w_high_from = div - (div >> 1);

  assign wrap    = (r_count == w_last);
  assign count   = r_count;
  assign clk_out = (r_count >= w_high_from);

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/freqdiv_ctrl.sv
// Run control, divisor configuration handshake and tick/done pulse generation
// around the period counter.
module freqdiv_ctrl
  import freqdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = FREQDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             oneshot,
  input  logic             stop,
  output logic             tick,
  output logic             done,
  output logic             clk_out,
  output logic             busy,
  output logic [WIDTH-1:0] div_active
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_div;
  logic             r_os;
  logic             r_tick;
  logic             r_done;

  logic             w_en;
  logic             w_clr;
  logic             w_cfg_load;
  logic             w_os_load;
  logic             w_tick_nxt;
  logic             w_done_nxt;
  logic             w_wrap;
  logic             w_core_clk;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_cfg_div;

  assign w_cfg_div = (cfg_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : cfg_div;

  freqdiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (w_en),
    .clr    (w_clr),
    .div    (r_div),
    .wrap   (w_wrap),
    .count  (w_count),
    .clk_out(w_core_clk)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_en        = 1'b0;
    w_clr       = 1'b0;
    w_cfg_load  = 1'b0;
    w_os_load   = 1'b0;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cfg_load = cfg_valid;
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_clr       = 1'b1;
          w_os_load   = 1'b1;
        end
      end
      S_RUN: begin
        // Stop takes priority over a wrap on the same edge.
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else begin
          w_en = 1'b1;
          if (w_wrap) begin
            w_tick_nxt = 1'b1;
            if (r_os) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= WIDTH'(DEFAULT_DIV);
      r_os   <= 1'b0;
      r_tick <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_cfg_load) r_div <= w_cfg_div;
      if (w_os_load)  r_os  <= oneshot;
      r_tick <= w_tick_nxt;
      r_done <= w_done_nxt;
    end
  end

  a_count_in_range : assert property (@(posedge clk) disable iff (rst) w_count < r_div);

  assign busy       = (r_state == S_RUN);
  assign cfg_ready  = (r_state == S_IDLE);
  assign clk_out    = busy & w_core_clk;
  assign tick       = r_tick;
  assign done       = r_done;
  assign div_active = r_div;

endmodule

// File: doc/freqdiv_ctrl.md
# freqdiv_ctrl

Programmable, run-controlled frequency-divider controller for the input-control path. It replaces the fixed divide-by-100 prescaler with a divisor loaded over a valid/ready handshake. It produces a one-cycle `tick` enable and a near-50% `clk_out` level, in either continuous or one-shot mode. Downstream input-control logic (sampling, debounce, scan timing) uses `tick` as a clock enable on the single system clock.

## Interface
- `WIDTH`, 16: divisor and counter width.
- `DEFAULT_DIV`, 100: divisor after reset; must be ≥2 and <2^WIDTH.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset; one clock; synchronous, active-high.
- `cfg_valid` in 1: new divisor offered on `cfg_div`.
- `cfg_div` in WIDTH: requested divisor.
- `cfg_ready` out 1: high only in IDLE; transfer occurs when `cfg_valid & cfg_ready`.
- `start` in 1: begin dividing; sampled in IDLE only.
- `oneshot` in 1: sampled with `start`; 1 = single period then stop.
- `stop` in 1: abort RUN; ignored in IDLE.
- `tick` out 1: one-cycle pulse at end of each period.
- `done` out 1: one-cycle pulse when a one-shot period completes (coincident with its `tick`).
- `clk_out` out 1: divided level, low first half, high second half.
- `busy` out 1: high in RUN.
- `div_active` out WIDTH: divisor currently in effect.

## Operation
- States: IDLE, RUN. Mode register `os_q` latched on start.
- Reset: state IDLE, `div_active`=DEFAULT_DIV, count=0, `os_q`=0, `tick`=0, `done`=0, `busy`=0, `cfg_ready`=1, `clk_out`=0.
- Config (IDLE only): on transfer, `div_active` ← max(`cfg_div`, 2); values 0 and 1 clamp to 2. `cfg_valid` in RUN is not accepted and has no effect; the requester holds it until IDLE.
- IDLE→RUN on `start & ~stop`: count←0, `os_q`←`oneshot`. If config transfer and start share a cycle, the new divisor applies to this run.
- `start & stop` together in IDLE: stay IDLE, no count change.
- RUN: count increments each cycle. At count==`div_active`−1: count←0 and registered `tick`←1. If `os_q`, also `done`←1 and state←IDLE.
- RUN→IDLE on `stop`: count←0, `tick`/`done` not asserted that edge, even if count==`div_active`−1. Stop wins over wrap.
- `start` in RUN ignored. No restart without passing through IDLE.
- `clk_out` = (count ≥ `div_active` − `div_active`/2) while RUN, else 0. Combinational from registered count/divisor. For 100: 50 low, 50 high. For 5: 3 low, 2 high.
- Arithmetic unsigned, WIDTH bits. Count never exceeds `div_active`−1; no wrap beyond that.

## Timing
- `start` sampled at edge E0 → `busy`=1 after E0. First `tick` is high for the cycle after edge E0+`div_active`. Subsequent ticks every `div_active` cycles exactly.
- `tick` and `done` are registered and high exactly one cycle.
- One-shot: `busy` falls on the same edge that raises `tick`/`done`. `cfg_ready` returns the same edge.
- `stop` at edge Es → `busy`=0, count=0 after Es. A `start` at Es+1 begins a fresh full period.
- `rst` overrides everything on its edge, including mid-RUN. Outputs hold reset values from the following cycle. The divisor returns to DEFAULT_DIV.
- `cfg_ready` has no combinational dependence on `cfg_valid`.

## Structure
- Package `freqdiv_pkg`: state enum (IDLE, RUN), `MIN_DIV`=2, default divisor constant.
- Sub-module `freqdiv_core`: counter, wrap compare, `clk_out` compare. Inputs: `clk`, `rst`, `en`, `clr`, `div`. Outputs: `wrap`, `count`, `clk_out`.
- `freqdiv_ctrl`: FSM, config register, handshake, `tick`/`done` registers.

## Test plan
- Reset, no config, start continuous: `div_active`=100, `cfg_ready`=1 before start. First tick 100 cycles after start, then every 100. Exactly 20 ticks in 2000 cycles. `clk_out` 50 low/50 high.
- Load `cfg_div`=5 with start in the same cycle → ticks at start+5, +10, +15. `clk_out` pattern 0,0,0,1,1 per period.
- `cfg_div`=0 and `cfg_div`=1 → `div_active`=2, tick every 2 cycles. `cfg_valid` held during RUN → not accepted until the one-shot ends.
- One-shot, div 7 → single `tick`+`done` at start+7, `busy` falls the same edge. No further ticks over 50 cycles.
- Div 10, `stop` exactly at count 9 → no tick, IDLE next cycle. Restart gives the first tick 10 cycles later.
- Reset mid-RUN after loading div 8 → all outputs at reset values next cycle, `div_active`=100. `start & stop` together in IDLE stays IDLE.
